// File: rtl/led_pwm_ctrl.sv
// rtl/led_pwm_ctrl.sv - multi-channel LED driver with OFF/ON/BLINK/PWM modes
module led_pwm_ctrl #(
  parameter int N_LED      = 4,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 1000,
  parameter int ACTIVE_LOW = 1,
  parameter logic [N_LED-1:0] RESET_ON_MASK = N_LED'(4'b1000),
  localparam int SEL_W = (N_LED > 1) ? $clog2(N_LED) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [SEL_W-1:0]    wr_sel,
  input  logic [1:0]          wr_mode,
  input  logic [PWM_BITS-1:0] wr_duty,
  output logic                wr_ack,
  output logic                wr_err,
  output logic [N_LED-1:0]    led
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [N_LED-1:0] LED_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_PWM   = 2'd3;

  logic [PS_W-1:0]                  ps_q, ps_d;
  logic [PWM_BITS-1:0]              pwm_q, pwm_d;
  logic                             phase_q, phase_d;
  logic [N_LED-1:0][1:0]            mode_q, mode_d;
  logic [N_LED-1:0][PWM_BITS-1:0]   duty_q, duty_d;
  logic                             ack_q, ack_d;
  logic                             err_q, err_d;
  logic [N_LED-1:0]                 led_q, led_d;
  logic [N_LED-1:0]                 lit;
  logic                             tick;
  logic                             wr_ok;

  assign tick  = (ps_q == PS_LAST);
  assign wr_ok = (int'(wr_sel) < N_LED);

  // Timebase: writes never touch these, so all channels stay phase-aligned.
  always_comb begin
    ps_d    = tick ? '0 : ps_q + 1'b1;
    pwm_d   = pwm_q;
    phase_d = phase_q;
    if (tick) begin
      pwm_d = pwm_q + 1'b1;
      if (pwm_q == '1) begin
        phase_d = ~phase_q;
      end
    end
  end

  always_comb begin
    mode_d = mode_q;
    duty_d = duty_q;
    ack_d  = 1'b0;
    err_d  = 1'b0;
    if (wr_en) begin
      if (wr_ok) begin
        ack_d = 1'b1;
        for (int i = 0; i < N_LED; i++) begin
          if (wr_sel == SEL_W'(i)) begin
            mode_d[i] = wr_mode;
            duty_d[i] = wr_duty;
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    lit = '0;
    for (int i = 0; i < N_LED; i++) begin
      case (mode_q[i])
        MODE_OFF:   lit[i] = 1'b0;
        MODE_ON:    lit[i] = 1'b1;
        MODE_BLINK: lit[i] = phase_q;
        MODE_PWM:   lit[i] = (pwm_q < duty_q[i]);
        default:    lit[i] = 1'b0;
      endcase
    end
    led_d = (ACTIVE_LOW != 0) ? ~lit : lit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q    <= '0;
      pwm_q   <= '0;
      phase_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      led_q   <= LED_IDLE;
      duty_q  <= '0;
      for (int i = 0; i < N_LED; i++) begin
        mode_q[i] <= RESET_ON_MASK[i] ? MODE_ON : MODE_OFF;
      end
    end else begin
      ps_q    <= ps_d;
      pwm_q   <= pwm_d;
      phase_q <= phase_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      led_q   <= led_d;
      mode_q  <= mode_d;
      duty_q  <= duty_d;
    end
  end

  assign wr_ack = ack_q;
  assign wr_err = err_q;
  assign led    = led_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// tb/tb_led_pwm_ctrl.sv - random + directed bench for led_pwm_ctrl against a cycle-count model
module tb_led_pwm_ctrl;

  localparam int PS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_sel = '0;
  logic [1:0] wr_mode = '0;
  logic [3:0] wr_duty = '0;
  logic       ack4, err4, ack3, err3;
  logic [3:0] led4;
  logic [2:0] led3;

  int errors = 0;
  int checks = 0;
  int n = 0;
  logic [3:0][1:0] m4, m3;
  logic [3:0][3:0] d4, d3;

  always #5 clk = ~clk;

  led_pwm_ctrl #(.N_LED(4), .PWM_BITS(4), .PRESCALE(PS), .ACTIVE_LOW(1), .RESET_ON_MASK(4'b1000)) u_dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_mode(wr_mode),
    .wr_duty(wr_duty), .wr_ack(ack4), .wr_err(err4), .led(led4));

  led_pwm_ctrl #(.N_LED(3), .PWM_BITS(4), .PRESCALE(PS), .ACTIVE_LOW(1), .RESET_ON_MASK(3'b100)) u_dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_mode(wr_mode),
    .wr_duty(wr_duty), .wr_ack(ack3), .wr_err(err3), .led(led3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counters derived purely from elapsed cycles since reset release.
  function automatic logic [3:0] model_led(input logic [3:0][1:0] md, input logic [3:0][3:0] dt, input int cyc);
    int   pwm = (cyc / PS) % 16;
    logic ph  = ((cyc / (PS * 16)) % 2) == 1;
    logic [3:0] lit = '0;
    for (int i = 0; i < 4; i++) begin
      case (md[i])
        2'd0: lit[i] = 1'b0;
        2'd1: lit[i] = 1'b1;
        2'd2: lit[i] = ph;
        default: lit[i] = (pwm < int'(dt[i]));
      endcase
    end
    return ~lit;
  endfunction

  task automatic model_reset();
    m4 = '0; m4[3] = 2'd1; d4 = '0;
    m3 = '0; m3[2] = 2'd1; d3 = '0;
    n = 0;
  endtask

  task automatic step(input logic en, input logic [1:0] sel, input logic [1:0] mode, input logic [3:0] duty);
    logic [3:0] e4, e3;
    e4 = model_led(m4, d4, n);
    e3 = model_led(m3, d3, n);
    wr_en = en; wr_sel = sel; wr_mode = mode; wr_duty = duty;
    if (en) begin
      m4[sel] = mode; d4[sel] = duty;
      if (sel < 2'd3) begin
        m3[sel] = mode; d3[sel] = duty;
      end
    end
    @(posedge clk); #1;
    n++;
    wr_en = 1'b0;
    chk("led4", 32'(led4), 32'(e4));
    chk("led3", 32'(led3), 32'(e3[2:0]));
    chk("ack4", 32'(ack4), 32'(en));
    chk("err4", 32'(err4), 32'(0));
    chk("ack3", 32'(ack3), 32'(en && sel < 2'd3));
    chk("err3", 32'(err3), 32'(en && sel == 2'd3));
  endtask

  task automatic idle_count(input int cycles, input int ch, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      step(1'b0, 2'd0, 2'd0, 4'd0);
      if (led4[ch] == 1'b0) lows++;
    end
  endtask

  initial begin
    int lows;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_led4", 32'(led4), 32'hF);
    chk("rst_led3", 32'(led3), 32'h7);
    chk("rst_ack", 32'({ack4, ack3}), 32'(0));
    chk("rst_err", 32'({err4, err3}), 32'(0));
    rst = 1'b0;
    step(1'b0, 2'd0, 2'd0, 4'd0);
    chk("first_edge", 32'(led4), 32'h7);

    step(1'b1, 2'd0, 2'd3, 4'd4);
    idle_count(64, 0, lows);
    chk("pwm4_lows", 32'(lows), 32'd16);

    step(1'b1, 2'd1, 2'd2, 4'd9);
    idle_count(128, 1, lows);
    chk("blink_lows", 32'(lows), 32'd64);

    step(1'b1, 2'd2, 2'd3, 4'd0);
    idle_count(64, 2, lows);
    chk("duty0_lows", 32'(lows), 32'd0);
    step(1'b1, 2'd2, 2'd3, 4'd15);
    idle_count(64, 2, lows);
    chk("duty15_lows", 32'(lows), 32'd60);

    step(1'b1, 2'd3, 2'd0, 4'd7);
    step(1'b1, 2'd0, 2'd1, 4'd3);
    step(1'b1, 2'd0, 2'd0, 4'd5);
    step(1'b0, 2'd0, 2'd0, 4'd0);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)));
    end

    #3 rst = 1'b1;
    #1;
    chk("async_led4", 32'(led4), 32'hF);
    chk("async_led3", 32'(led3), 32'h7);
    @(posedge clk); #1;
    chk("hold_led4", 32'(led4), 32'hF);
    chk("hold_ack", 32'({ack4, ack3, err4, err3}), 32'(0));
    rst = 1'b0;
    model_reset();
    step(1'b0, 2'd0, 2'd0, 4'd0);
    chk("rerelease", 32'(led4), 32'h7);
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pwm_ctrl.md
LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

Interface
REQ-001 SHALL have parameter N_LED, default 4, meaning number of LED channels (1..16).
REQ-002 SHALL have parameter PWM_BITS, default 8, meaning PWM counter and duty width.
REQ-003 SHALL have parameter PRESCALE, default 1000, meaning clk cycles per PWM step (>=1).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1, meaning 1 = LED lit when pin is 0.
REQ-005 SHALL have parameter RESET_ON_MASK, default N_LED'b1000, meaning channels forced ON at reset.
REQ-006 SHALL have port clk, input, 1, meaning the single clock, all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, meaning asynchronous, active-high reset.
REQ-008 SHALL have port wr_en, input, 1, meaning a one-cycle channel configuration write strobe.
REQ-009 SHALL have port wr_sel, input, SEL_W = max(1, clog2(N_LED)), meaning the target channel index.
REQ-010 SHALL have port wr_mode, input, 2, meaning the mode: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
REQ-011 SHALL have port wr_duty, input, PWM_BITS, meaning the PWM duty value.
REQ-012 SHALL have port wr_ack, output, 1, meaning a one-cycle pulse on an accepted write.
REQ-013 SHALL have port wr_err, output, 1, meaning a one-cycle pulse on a rejected write.
REQ-014 SHALL have port led, output, N_LED, meaning registered LED pins at the ACTIVE_LOW polarity.

Function
REQ-015 The prescaler SHALL count 0..PRESCALE-1, wrap to 0, and assert internal tick in the cycle it equals PRESCALE-1.
REQ-016 The PWM counter (PWM_BITS) SHALL increment only on tick and wrap from all-ones to 0.
REQ-017 The blink phase bit SHALL toggle on a tick where the PWM counter is all-ones; blink period = 2*PRESCALE*2^PWM_BITS clk cycles.
REQ-018 lit[i] SHALL be: OFF -> 0; ON -> 1; BLINK -> phase; PWM -> (pwm_cnt < duty[i]), unsigned compare.
REQ-019 PWM duty 0 SHALL never light; duty all-ones SHALL light 2^PWM_BITS-1 of 2^PWM_BITS steps.
REQ-020 led[i] SHALL be registered each clk as ~lit[i] if ACTIVE_LOW=1, else lit[i]; output latency is 1 clk from the channel state.
REQ-021 A write sampled at edge k with wr_sel < N_LED SHALL update mode/duty of that channel at edge k; led reflects the change at edge k+1.
REQ-022 For an accepted write, wr_ack SHALL be high for exactly the cycle after edge k.
REQ-023 A write with wr_sel >= N_LED SHALL change no state and SHALL pulse wr_err for one cycle instead of wr_ack.
REQ-024 Back-to-back writes on consecutive cycles SHALL each be accepted; the last write to a channel wins.
REQ-025 Writes SHALL NOT reset or disturb the prescaler, PWM counter or blink phase.
REQ-026 wr_duty SHALL be stored for every accepted write regardless of mode; it is used only in PWM mode.

Reset
REQ-027 While rst is high, prescaler, PWM counter, phase, wr_ack and wr_err SHALL be 0 and led SHALL be all inactive (all 1 when ACTIVE_LOW=1).
REQ-028 rst SHALL set mode[i] to ON where RESET_ON_MASK[i]=1 and OFF otherwise, and duty[i] to 0.
REQ-029 At the first edge after rst deasserts, led SHALL show RESET_ON_MASK (default N_LED=4, ACTIVE_LOW=1: 4'b0111).
REQ-030 rst asserted mid-write or mid-PWM period SHALL discard the write and take effect immediately without waiting for clk.

Verification (bench: N_LED=4, PWM_BITS=4, PRESCALE=4, ACTIVE_LOW=1)
REQ-031 Bench SHALL cover: release rst -> led=4'b1111 during reset, 4'b0111 after the first edge, with no wr_ack or wr_err.
REQ-032 Bench SHALL cover: write sel=0, mode=3, duty=4 -> wr_ack one cycle; led[0]=0 for 16 clks, then 1 for 48 clks, repeating every 64 clks.
REQ-033 Bench SHALL cover: write sel=1, mode=2 -> led[1] alternates every 64 clks (period 128).
REQ-034 Bench SHALL cover: write sel=2, mode=3, duty=0, then duty=15 -> led[2] stays 1 the whole period, then is 0 for 60 of 64 clks.
REQ-035 Bench SHALL cover: write sel=5 (SEL_W=2, so index 5 is unreachable; bench uses N_LED=3 with sel=3) -> wr_err one cycle, led unchanged.
REQ-036 Bench SHALL cover: assert rst asynchronously mid-PWM -> led=4'b1111 within the same cycle; modes return to the mask.
